// File: rtl/ms_path_checker.sv
// Snoops the serial maze stream into a local map, then checks the solver's
// path coordinate by coordinate and reports pass/first-error/step-count once per maze.
module ms_path_checker #(
    parameter int N      = 15,
    parameter int START  = 1,
    parameter int GOAL   = 13,
    parameter int STEP_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              maze,
    input  logic              out_valid,
    input  logic [3:0]        out_x,
    input  logic [3:0]        out_y,
    input  logic              maze_not_valid,
    output logic              chk_done,
    output logic              chk_pass,
    output logic [2:0]        chk_err,
    output logic [STEP_W-1:0] chk_steps
);

    localparam int CELLS = N * N;
    localparam int CNT_W = $clog2(CELLS);

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_WAIT = 2'd1,
        ST_PATH = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CELLS-1:0]   map_q, map_d;
    logic [CELLS-1:0]   vis_q, vis_d;
    logic [3:0]         prev_x_q, prev_x_d;
    logic [3:0]         prev_y_q, prev_y_d;
    logic [2:0]         err_q, err_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic               done_q, done_d;
    logic               pass_q, pass_d;
    logic [2:0]         err_out_q, err_out_d;
    logic [STEP_W-1:0]  steps_out_q, steps_out_d;

    logic               in_range_s;
    logic [CNT_W-1:0]   idx_s;
    logic               step_max_s;
    logic               first_s;
    logic               adj_s;
    logic [3:0]         dx_s, dy_s;
    logic [2:0]         coord_err_s;
    logic [2:0]         final_err_s;

    function automatic logic [3:0] abs_diff(input logic [3:0] a, input logic [3:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    assign in_range_s  = (out_x < 4'(N)) && (out_y < 4'(N));
    assign idx_s       = in_range_s ? (CNT_W'(out_x) * CNT_W'(N) + CNT_W'(out_y)) : '0;
    assign step_max_s  = (steps_q == {STEP_W{1'b1}});
    assign first_s     = (state_q == ST_WAIT);
    assign dx_s        = abs_diff(out_x, prev_x_q);
    assign dy_s        = abs_diff(out_y, prev_y_q);
    assign adj_s       = ((dx_s == 4'd1) && (dy_s == 4'd0)) || ((dx_s == 4'd0) && (dy_s == 4'd1));
    assign final_err_s = ((err_q == 3'd0) && ((prev_x_q != 4'(GOAL)) || (prev_y_q != 4'(GOAL))))
                         ? 3'd5 : err_q;

    // Error code of the current coordinate, highest priority first.
    always_comb begin
        coord_err_s = 3'd0;
        if (!in_range_s || step_max_s) begin
            coord_err_s = 3'd7;
        end else if (first_s && ((out_x != 4'(START)) || (out_y != 4'(START)))) begin
            coord_err_s = 3'd1;
        end else if (!first_s && !adj_s) begin
            coord_err_s = 3'd2;
        end else if (map_q[idx_s]) begin
            coord_err_s = 3'd3;
        end else if (vis_q[idx_s]) begin
            coord_err_s = 3'd4;
        end else begin
            coord_err_s = 3'd0;
        end
    end

    // Next-state, map updates and result registers.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        map_d       = map_q;
        vis_d       = vis_q;
        prev_x_d    = prev_x_q;
        prev_y_d    = prev_y_q;
        err_d       = err_q;
        steps_d     = steps_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        err_out_d   = err_out_q;
        steps_out_d = steps_out_q;

        case (state_q)
            ST_LOAD: begin
                vis_d   = '0;
                err_d   = 3'd0;
                steps_d = '0;
                if (in_valid) begin
                    map_d[cnt_q] = maze;
                    if (cnt_q == CNT_W'(CELLS - 1)) begin
                        cnt_d   = '0;
                        state_d = ST_WAIT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            ST_WAIT, ST_PATH: begin
                if ((state_q == ST_WAIT) && maze_not_valid) begin
                    done_d      = 1'b1;
                    pass_d      = 1'b0;
                    err_out_d   = 3'd6;
                    steps_out_d = '0;
                    state_d     = ST_LOAD;
                end else if (out_valid) begin
                    // After the first error the rest of the path is only counted.
                    if (err_q == 3'd0) begin
                        err_d = coord_err_s;
                    end else begin
                        err_d = err_q;
                    end
                    if (in_range_s) begin
                        vis_d[idx_s] = 1'b1;
                    end else begin
                        vis_d = vis_q;
                    end
                    prev_x_d = out_x;
                    prev_y_d = out_y;
                    steps_d  = step_max_s ? steps_q : (steps_q + 1'b1);
                    state_d  = ST_PATH;
                end else if (state_q == ST_PATH) begin
                    done_d      = 1'b1;
                    pass_d      = (final_err_s == 3'd0);
                    err_out_d   = final_err_s;
                    steps_out_d = steps_q;
                    state_d     = ST_LOAD;
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = ST_LOAD;
                cnt_d   = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            map_q       <= '0;
            vis_q       <= '0;
            prev_x_q    <= 4'd0;
            prev_y_q    <= 4'd0;
            err_q       <= 3'd0;
            steps_q     <= '0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_out_q   <= 3'd0;
            steps_out_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            map_q       <= map_d;
            vis_q       <= vis_d;
            prev_x_q    <= prev_x_d;
            prev_y_q    <= prev_y_d;
            err_q       <= err_d;
            steps_q     <= steps_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            err_out_q   <= err_out_d;
            steps_out_q <= steps_out_d;
        end
    end

    assign chk_done  = done_q;
    assign chk_pass  = pass_q;
    assign chk_err   = err_out_q;
    assign chk_steps = steps_out_q;

endmodule

// File: tb/tb_ms_path_checker.sv
// Directed self-checking bench for ms_path_checker: loads mazes, drives paths,
// and compares the result pulse against hand-computed codes and step counts.
module tb_ms_path_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic       maze = 1'b0;
    logic       out_valid = 1'b0;
    logic [3:0] out_x = 4'd0;
    logic [3:0] out_y = 4'd0;
    logic       maze_not_valid = 1'b0;
    logic       chk_done;
    logic       chk_pass;
    logic [2:0] chk_err;
    logic [7:0] chk_steps;

    int tests_run = 0;
    int tests_failed = 0;

    logic [3:0] qx[$];
    logic [3:0] qy[$];

    ms_path_checker dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .maze           (maze),
        .out_valid      (out_valid),
        .out_x          (out_x),
        .out_y          (out_y),
        .maze_not_valid (maze_not_valid),
        .chk_done       (chk_done),
        .chk_pass       (chk_pass),
        .chk_err        (chk_err),
        .chk_steps      (chk_steps)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [224:0] corridor();
        logic [224:0] m;
        m = '0;
        for (int r = 0; r < 15; r++) begin
            for (int c = 0; c < 15; c++) begin
                m[r*15+c] = (r == 0) || (r == 14) || (c == 0) || (c == 14);
            end
        end
        return m;
    endfunction

    task automatic load_maze(input logic [224:0] m, input bit gaps);
        for (int k = 0; k < 225; k++) begin
            if (gaps && ($urandom_range(0, 2) == 0)) begin
                in_valid = 1'b0;
                maze     = 1'b1;
                tick();
            end
            in_valid = 1'b1;
            maze     = m[k];
            tick();
        end
        in_valid = 1'b0;
        maze     = 1'b0;
    endtask

    task automatic add(input int x, input int y);
        qx.push_back(4'(x));
        qy.push_back(4'(y));
    endtask

    // Row 1 across to column 13, then down column 13 to last_row.
    task automatic add_good(input int first_col, input int last_row);
        for (int c = first_col; c <= 13; c++) add(1, c);
        for (int r = 2; r <= last_row; r++) add(r, 13);
    endtask

    task automatic drive_coords();
        for (int i = 0; i < qx.size(); i++) begin
            out_valid = 1'b1;
            out_x     = qx[i];
            out_y     = qy[i];
            tick();
        end
        out_valid = 1'b0;
        qx.delete();
        qy.delete();
    endtask

    task automatic run_path();
        drive_coords();
        tick();
    endtask

    task automatic check_result(input string tag, input logic exp_pass, input logic [2:0] exp_err,
                                input logic [7:0] exp_steps);
        check_eq({tag, "_done"},  32'(chk_done),  32'd1);
        check_eq({tag, "_pass"},  32'(chk_pass),  32'(exp_pass));
        check_eq({tag, "_err"},   32'(chk_err),   32'(exp_err));
        check_eq({tag, "_steps"}, 32'(chk_steps), 32'(exp_steps));
        tick();
        check_eq({tag, "_done_1cyc"}, 32'(chk_done), 32'd0);
        check_eq({tag, "_err_held"},  32'(chk_err),  32'(exp_err));
    endtask

    initial begin
        logic [224:0] open_m;
        logic [224:0] wall_m;
        open_m = corridor();
        wall_m = open_m;
        wall_m[1*15+2] = 1'b1;

        tick();
        tick();
        check_eq("rst_done",  32'(chk_done),  32'd0);
        check_eq("rst_pass",  32'(chk_pass),  32'd0);
        check_eq("rst_err",   32'(chk_err),   32'd0);
        check_eq("rst_steps", 32'(chk_steps), 32'd0);
        rst_n = 1'b0;
        tick();

        load_maze(open_m, 1'b0);
        add_good(1, 13);
        run_path();
        check_result("good", 1'b1, 3'd0, 8'd25);

        load_maze(open_m, 1'b0);
        add_good(2, 13);
        run_path();
        check_result("bad_start", 1'b0, 3'd1, 8'd24);

        load_maze(open_m, 1'b0);
        add(1, 1); add(1, 2); add(2, 3); add(1, 3); add(1, 2);
        run_path();
        check_result("nonadj", 1'b0, 3'd2, 8'd5);

        load_maze(wall_m, 1'b1);
        add(1, 1); add(1, 2);
        run_path();
        check_result("wall", 1'b0, 3'd3, 8'd2);

        load_maze(open_m, 1'b0);
        add(1, 1); add(1, 2); add(1, 1);
        run_path();
        check_result("revisit", 1'b0, 3'd4, 8'd3);

        load_maze(open_m, 1'b0);
        add_good(1, 12);
        run_path();
        check_result("short", 1'b0, 3'd5, 8'd24);

        load_maze(open_m, 1'b0);
        add(1, 1); add(15, 1);
        run_path();
        check_result("range", 1'b0, 3'd7, 8'd2);

        // maze_not_valid wins over a simultaneous coordinate.
        load_maze(open_m, 1'b0);
        maze_not_valid = 1'b1;
        out_valid      = 1'b1;
        out_x          = 4'd1;
        out_y          = 4'd1;
        tick();
        maze_not_valid = 1'b0;
        out_valid      = 1'b0;
        check_result("mnv", 1'b0, 3'd6, 8'd0);
        add(1, 1); add(1, 2); add(1, 3);
        drive_coords();
        tick();
        tick();
        check_eq("load_ignores_path", 32'(chk_done), 32'd0);

        // Reset mid-path, then mid-load, then a gapped reload must behave cleanly.
        load_maze(open_m, 1'b0);
        add(1, 1); add(1, 2); add(1, 3);
        for (int i = 0; i < 3; i++) begin
            out_valid = 1'b1;
            out_x     = qx[i];
            out_y     = qy[i];
            tick();
        end
        qx.delete();
        qy.delete();
        rst_n     = 1'b1;
        out_valid = 1'b0;
        #1;
        check_eq("midrst_pass", 32'(chk_pass), 32'd0);
        check_eq("midrst_err",  32'(chk_err),  32'd0);
        tick();
        rst_n = 1'b0;
        for (int k = 0; k < 50; k++) begin
            in_valid = 1'b1;
            maze     = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        rst_n    = 1'b1;
        tick();
        rst_n = 1'b0;
        tick();
        load_maze(open_m, 1'b1);
        add_good(1, 13);
        run_path();
        check_result("after_rst", 1'b1, 3'd0, 8'd25);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ms_path_checker.md
Name: ms_path_checker

Overview:
- Sits directly downstream of the maze solver and snoops the same serial maze stream into its own copy of the maze.
- Consumes the solver's path output (out_valid/out_x/out_y) or its unsolvable flag (maze_not_valid).
- Checks the path step by step and reports pass/fail, the first error code and the step count once per maze.
- Used as an in-system self-checker and as the scoreboard in solver benches.

Parameters:
- N, 15, maze side length; maze holds N*N bits.
- START, 1, start cell (row START, col START).
- GOAL, 13, goal cell (row GOAL, col GOAL).
- STEP_W, 8, width of the step counter.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-high (asserted = 1). The name is kept for codebase consistency.
- in_valid  in  1  maze bit valid.
- maze  in  1  maze bit: 1 = wall, 0 = open.
- out_valid  in  1  solver path coordinate valid.
- out_x  in  4  path row.
- out_y  in  4  path column.
- maze_not_valid  in  1  solver claims the maze has no path.
- chk_done  out  1  one-cycle result pulse.
- chk_pass  out  1  path accepted; held until next chk_done.
- chk_err  out  3  first error code; held until next chk_done.
- chk_steps  out  STEP_W  coordinates received; held until next chk_done.

Behaviour:
- Reset (asynchronous, rst_n=1):
  - state=LOAD; bit counter=0; maze and visited maps cleared.
  - Outputs: chk_done=0, chk_pass=0, chk_err=0, chk_steps=0.
  - Reset mid-operation discards everything; the next in_valid bit is maze bit 0.
- Maze order: row-major, first bit = map[0][0], bit k stored at map[k/N][k%N].
- LOAD:
  - Each sampled in_valid=1 stores maze and increments the counter. Gaps in in_valid are allowed; the counter holds.
  - Visited map is cleared.
  - At the edge storing bit N*N-1: counter to 0, state to WAIT.
  - out_valid and maze_not_valid are ignored in LOAD.
- WAIT:
  - maze_not_valid=1 sampled: chk_done=1, chk_pass=0, chk_err=6, chk_steps=0; state to LOAD.
  - maze_not_valid has priority over a simultaneous out_valid.
  - out_valid=1 sampled: the coordinate is checked as step 1; state to PATH.
  - in_valid is ignored in WAIT.
- Per-coordinate checks (each sampled out_valid=1 in WAIT or PATH):
  - Checks apply only while the error register is 0; only the first error is latched.
  - Codes in priority order within one cycle:
    - 7: out_x>=N or out_y>=N, or step count already at max.
    - 1: step 1 is not (START,START).
    - 2: not 4-adjacent to the previous coordinate (|dx|+|dy| != 1); not checked on step 1.
    - 3: map[out_x][out_y]=1 (wall).
    - 4: visited[out_x][out_y]=1 (revisit).
  - Every accepted coordinate sets its visited bit, updates the previous coordinate and increments steps, saturating at 2^STEP_W-1.
  - Once an error is latched, the rest of the path is consumed without checking; steps keep counting.
- PATH end:
  - The first sampled out_valid=0 ends the path; one idle gap is treated as the end.
  - If the error register is 0 and the previous coordinate != (GOAL,GOAL), error 5 is latched.
  - At that same edge: chk_done=1, chk_pass=(err==0), chk_err and chk_steps updated; state to LOAD.
- Latency: chk_done is visible the cycle after the edge that samples the terminating condition. It is exactly one cycle wide.
- in_valid during PATH is a protocol violation and is ignored. Bits arriving after the return to LOAD start the next maze.
- Maze and visited maps are 225-bit flop arrays with no RAM. All comparisons are unsigned, 4-bit.

Test Plan:
- Open-corridor maze (border walls, interior open), path (1,1)->(1,2)...(1,13)->(2,13)...(13,13) (25 coords) -> chk_done pulse, pass=1, err=0, steps=25.
- Same maze, path starting at (1,2) -> pass=0, err=1, steps equals the full coordinate count.
- Path (1,1),(1,2),(2,3) -> err=2 latched at step 3; later errors in the same path do not overwrite it.
- Wall at map[1][2], path enters (1,2) -> err=3; path (1,1),(1,2),(1,1) on open maze -> err=4.
- Valid path stopping at (12,13) -> err=5. maze_not_valid pulse in WAIT -> err=6, steps=0, no PATH entry.
- Assert rst_n mid-PATH, then reload a maze and send a valid path -> clean pass with correct steps. Also: 225 bits sent with random in_valid gaps -> map identical to the gap-free load.
